shift_reg_tap_edge: RTL and testbench

//  Parametrised WIDTH-bit x DEPTH-stage shift register with shift enable, synchronous flush,

---
 rtl/shift_reg_pkg.sv | 27 ++
 rtl/shift_edge_detect.sv | 47 ++++
 rtl/shift_reg_tap_edge.sv | 90 +++++++++
 tb/tb_shift_reg_tap_edge.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/shift_reg_pkg.sv
// Shared helpers for shift_reg_tap_edge: counter-width function, parameter
// legality check and the stage indices used when slicing the tap bus.
package shift_reg_pkg;

  localparam int unsigned STAGE0    = 0;
  localparam int unsigned STAGE1    = 1;
  localparam int unsigned MIN_WIDTH = 1;
  localparam int unsigned MIN_DEPTH = 2;

  // Smallest r with 2**r >= n.
  function automatic int unsigned shreg_clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v * 2;
      r = r + 1;
    end
    return r;
  endfunction

  function automatic bit shreg_params_ok(input int unsigned w, input int unsigned d);
    return (w >= MIN_WIDTH) && (d >= MIN_DEPTH);
  endfunction

endpackage

// File: rtl/shift_edge_detect.sv
// Per-bit rise/fall decoder between two adjacent stages, qualified by edge_q.
// With SHREG_EDGE_REG_EN defined the pulses are registered (one cycle later).
module shift_edge_detect
  import shift_reg_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             clear_i,
  input  logic [WIDTH-1:0] cur_i,
  input  logic [WIDTH-1:0] prev_i,
  input  logic             qual_i,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o
);

  logic [WIDTH-1:0] rise_d;
  logic [WIDTH-1:0] fall_d;

  assign rise_d = cur_i & ~prev_i & {WIDTH{qual_i}};
  assign fall_d = ~cur_i & prev_i & {WIDTH{qual_i}};

`ifdef SHREG_EDGE_REG_EN
  logic [WIDTH-1:0] rise_q;
  logic [WIDTH-1:0] fall_q;

  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;
`else
  logic unused_clk_clear;
  assign unused_clk_clear = clk_i ^ clear_i;

  assign rise_o = rise_d;
  assign fall_o = fall_d;
`endif

endmodule

// File: rtl/shift_reg_tap_edge.sv
// WIDTH x DEPTH shift register with enable, flush, fill tracking and edge pulses
// on stage0/stage1. SHREG_EDGE_REG_EN adds an output register on rise/fall.
module shift_reg_tap_edge
  import shift_reg_pkg::*;
#(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   shift_en,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       data_in,
  output logic [WIDTH-1:0]       data_out,
  output logic [WIDTH*DEPTH-1:0] taps,
  output logic [WIDTH-1:0]       rise,
  output logic [WIDTH-1:0]       fall,
  output logic                   primed
);

  localparam int unsigned FILL_W = shreg_clog2(DEPTH + 1);

  if (!shreg_params_ok(WIDTH, DEPTH)) begin : g_bad_params
    $error("shift_reg_tap_edge: requires WIDTH>=1 and DEPTH>=2");
  end

  logic [DEPTH-1:0][WIDTH-1:0] stage_q;
  logic [DEPTH-1:0][WIDTH-1:0] stage_d;
  logic [FILL_W-1:0]           fill_q;
  logic [FILL_W-1:0]           fill_d;
  logic                        edge_q;
  logic                        edge_d;
  logic                        primed_q;
  logic                        primed_d;

  // Stage 0 loads data_in, every other stage takes its predecessor.
  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign stage_d[k] = flush ? '0 : (shift_en ? data_in : stage_q[k]);
    end else begin : g_body
      assign stage_d[k] = flush ? '0 : (shift_en ? stage_q[k-1] : stage_q[k]);
    end
  end

  // edge_d uses the pre-increment count: stage1 is real once a second shift lands.
  always_comb begin
    fill_d = fill_q;
    edge_d = 1'b0;
    if (flush) begin
      fill_d = '0;
    end else if (shift_en) begin
      edge_d = (fill_q != '0);
      if (fill_q != FILL_W'(DEPTH)) begin
        fill_d = fill_q + FILL_W'(1);
      end
    end
    primed_d = (fill_d == FILL_W'(DEPTH));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stage_q  <= '0;
      fill_q   <= '0;
      edge_q   <= 1'b0;
      primed_q <= 1'b0;
    end else begin
      stage_q  <= stage_d;
      fill_q   <= fill_d;
      edge_q   <= edge_d;
      primed_q <= primed_d;
    end
  end

  assign data_out = stage_q[DEPTH-1];
  assign taps     = stage_q;
  assign primed   = primed_q;

  shift_edge_detect #(
    .WIDTH (WIDTH)
  ) u_edge (
    .clk_i   (clock),
    .clear_i (reset | flush),
    .cur_i   (stage_q[STAGE0]),
    .prev_i  (stage_q[STAGE1]),
    .qual_i  (edge_q),
    .rise_o  (rise),
    .fall_o  (fall)
  );

endmodule

// File: tb/tb_shift_reg_tap_edge.sv
// Scoreboard bench for shift_reg_tap_edge (WIDTH=8, DEPTH=4): directed scenarios
// followed by random traffic, checked against a queue-of-stages reference model.
module tb_shift_reg_tap_edge;

  localparam int unsigned W = 8;
  localparam int unsigned D = 4;

  logic             clock;
  logic             reset;
  logic             shift_en;
  logic             flush;
  logic [W-1:0]     data_in;
  logic [W-1:0]     data_out;
  logic [W*D-1:0]   taps;
  logic [W-1:0]     rise;
  logic [W-1:0]     fall;
  logic             primed;

  typedef struct {
    logic [W-1:0]   data_out;
    logic [W*D-1:0] taps;
    logic [W-1:0]   rise;
    logic [W-1:0]   fall;
    logic           primed;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   rise_seen = 0;
  int   fall_seen = 0;

  // Reference model state
  logic [W-1:0] m_st[D];
  int           m_fill = 0;
  bit           m_edge = 1'b0;

  shift_reg_tap_edge #(.WIDTH(W), .DEPTH(D)) dut (
    .clock    (clock),
    .reset    (reset),
    .shift_en (shift_en),
    .flush    (flush),
    .data_in  (data_in),
    .data_out (data_out),
    .taps     (taps),
    .rise     (rise),
    .fall     (fall),
    .primed   (primed)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs and push the expected post-edge outputs.
  task automatic step(input bit r, input bit f, input bit s, input logic [W-1:0] d);
    exp_t         e;
    logic [W-1:0] rc;
    logic [W-1:0] fc;
    @(negedge clock);
    reset = r; flush = f; shift_en = s; data_in = d;
    rc = m_edge ? (m_st[0] & ~m_st[1]) : '0;
    fc = m_edge ? (~m_st[0] & m_st[1]) : '0;
    if (r || f) begin
      for (int i = 0; i < D; i++) m_st[i] = '0;
      m_fill = 0;
      m_edge = 1'b0;
    end else if (s) begin
      m_edge = (m_fill >= 1);
      for (int i = D - 1; i > 0; i--) m_st[i] = m_st[i-1];
      m_st[0] = d;
      if (m_fill < D) m_fill++;
    end else begin
      m_edge = 1'b0;
    end
    e.data_out = m_st[D-1];
    for (int k = 0; k < D; k++) e.taps[k*W +: W] = m_st[k];
    e.primed = (m_fill == D);
`ifdef SHREG_EDGE_REG_EN
    e.rise = (r || f) ? '0 : rc;
    e.fall = (r || f) ? '0 : fc;
`else
    e.rise = m_edge ? (m_st[0] & ~m_st[1]) : '0;
    e.fall = m_edge ? (~m_st[0] & m_st[1]) : '0;
`endif
    exp_q.push_back(e);
  endtask

  // Monitor: every cycle presents an output, compare against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("data_out", 64'(data_out), 64'(e.data_out));
        chk("taps",     64'(taps),     64'(e.taps));
        chk("rise",     64'(rise),     64'(e.rise));
        chk("fall",     64'(fall),     64'(e.fall));
        chk("primed",   64'(primed),   64'(e.primed));
        if (rise != '0) rise_seen++;
        if (fall != '0) fall_seen++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < D; i++) m_st[i] = '0;
    reset = 1'b1; flush = 1'b0; shift_en = 1'b1; data_in = '1;

    // Reset held with shift enabled and all-ones input
    step(1, 0, 1, 8'hFF);
    step(1, 0, 1, 8'hFF);

    // Fill / latency
    step(0, 0, 1, 8'hA1);
    step(0, 0, 1, 8'hB2);
    step(0, 0, 1, 8'hC3);
    step(0, 0, 1, 8'hD4);

    // Hold
    for (int i = 0; i < 5; i++) step(0, 0, 0, W'($urandom));

    // Edges on every bit: 0, 1, 1, 0
    step(0, 1, 0, 8'h00);
    step(0, 0, 1, 8'h00);
    step(0, 0, 1, 8'hFF);
    step(0, 0, 1, 8'hFF);
    step(0, 0, 1, 8'h00);
    step(0, 0, 0, 8'h00);
    step(0, 0, 0, 8'h00);

    // Flush mid-stream, then a shift of ones must not produce a rise
    step(0, 0, 1, 8'h00);
    step(0, 0, 1, 8'h00);
    step(0, 0, 1, 8'h00);
    step(0, 1, 1, 8'h5A);
    step(0, 0, 1, 8'hFF);
    step(0, 0, 1, 8'h0F);
    step(0, 0, 0, 8'h00);

    // Saturation
    for (int i = 0; i < 20; i++) step(0, 0, 1, W'($urandom));

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 24) == 0),
           ($urandom_range(0, 9) < 7), W'($urandom));
    end

    step(0, 0, 0, 8'h00);
    step(0, 0, 0, 8'h00);
    @(negedge clock);

    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    chk("rise_observed", 64'(rise_seen > 0), 64'd1);
    chk("fall_observed", 64'(fall_seen > 0), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
